// File: rtl/match_referee_pkg.sv
// Shared types and helpers for the best-of-N match referee.
package match_pkg;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_COMPARE, S_SHOW, S_DONE} state_t;
  typedef enum logic [1:0] {RND_WIN, RND_LOSE, RND_TIE} rnd_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_LOCAL  = 2'b01;
  localparam logic [1:0] RES_REMOTE = 2'b10;
  localparam logic [1:0] RES_DRAW   = 2'b11;

  localparam int THERM_MAX = 64;

  // n ones from bit 0 upward, clipped to width
  function automatic logic [THERM_MAX-1:0] therm(input int n, input int width);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_MAX; i++)
      if (i < n && i < width) t[i] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/match_referee_if.sv
// Strobe/score inputs and LED/status outputs of the match referee.
interface match_referee_if #(
  parameter int SCORE_W = 4,
  parameter int LED_W   = 16
);
  logic               start;
  logic               l_valid;
  logic [SCORE_W-1:0] score;
  logic               r_valid;
  logic [SCORE_W-1:0] r_score;
  logic [LED_W-1:0]   led;
  logic [3:0]         l_wins;
  logic [3:0]         r_wins;
  logic               match_over;
  logic [1:0]         result;

  modport master (output start, l_valid, score, r_valid, r_score,
                  input  led, l_wins, r_wins, match_over, result);
  modport slave  (input  start, l_valid, score, r_valid, r_score,
                  output led, l_wins, r_wins, match_over, result);
endinterface

// File: rtl/match_referee_timer.sv
// Loadable down-counter; done is high during the last counted cycle.
module match_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign done = (cnt == W'(1));
endmodule

// File: rtl/match_referee.sv
// Best-of-N referee: latches both round scores, scores the round, tracks
// wins and drives the LED bar with progress and results.
module match_referee
  import match_pkg::*;
#(
  parameter int SCORE_W   = 4,
  parameter int N_ROUNDS  = 3,
  parameter int LED_W     = 16,
  parameter int SHOW_CYC  = 50_000_000,
  parameter int BLINK_CYC = 12_500_000
) (
  input  logic            clk,
  input  logic            reset,
  match_referee_if.slave  bus
);
  localparam logic [3:0] WIN_TGT = 4'((N_ROUNDS + 1) / 2);

  state_t             state, state_n;
  rnd_t               rnd, rnd_n;
  logic               l_got, r_got, l_got_n, r_got_n;
  logic [SCORE_W-1:0] l_sc, r_sc, l_sc_n, r_sc_n;
  logic [3:0]         l_wins, r_wins, rounds, l_wins_n, r_wins_n, rounds_n;
  logic               blink, blink_n, mo_q, mo_n;
  logic [1:0]         res_q, res_n;
  logic [LED_W-1:0]   led_q, led_n, rt;
  logic               show_load, show_done, blink_load, blink_done, cap_en;

  match_timer #(.W(32)) u_show (
    .clk(clk), .reset(reset), .load(show_load),
    .load_val(32'(SHOW_CYC)), .done(show_done)
  );

  match_timer #(.W(32)) u_blink (
    .clk(clk), .reset(reset), .load(blink_load),
    .load_val(32'(BLINK_CYC)), .done(blink_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;  rnd   <= RND_TIE;
      l_got <= 1'b0;    r_got <= 1'b0;
      l_sc  <= '0;      r_sc  <= '0;
      l_wins <= '0;     r_wins <= '0;    rounds <= '0;
      blink <= 1'b0;    mo_q  <= 1'b0;   res_q <= RES_NONE;
      led_q <= '0;
    end else begin
      state <= state_n; rnd   <= rnd_n;
      l_got <= l_got_n; r_got <= r_got_n;
      l_sc  <= l_sc_n;  r_sc  <= r_sc_n;
      l_wins <= l_wins_n; r_wins <= r_wins_n; rounds <= rounds_n;
      blink <= blink_n; mo_q  <= mo_n;   res_q <= res_n;
      led_q <= led_n;
    end
  end

  always_comb begin
    state_n  = state;  rnd_n    = rnd;
    l_sc_n   = l_sc;   r_sc_n   = r_sc;
    l_wins_n = l_wins; r_wins_n = r_wins; rounds_n = rounds;
    blink_n  = blink;  res_n    = res_q;
    show_load = 1'b0;  blink_load = 1'b0;
    rt = '0;

    // COMPARE consumes the held pair, so a strobe that cycle starts the next round
    l_got_n = (state == S_COMPARE) ? 1'b0 : l_got;
    r_got_n = (state == S_COMPARE) ? 1'b0 : r_got;
    cap_en  = (state == S_COLLECT) || (state == S_COMPARE) || (state == S_SHOW);
    if (cap_en && bus.l_valid && !l_got_n) begin
      l_sc_n = bus.score;   l_got_n = 1'b1;
    end
    if (cap_en && bus.r_valid && !r_got_n) begin
      r_sc_n = bus.r_score; r_got_n = 1'b1;
    end

    unique case (state)
      S_IDLE: if (bus.start) state_n = S_COLLECT;
      S_COLLECT: if (l_got && r_got) state_n = S_COMPARE;
      S_COMPARE: begin
        if (l_sc > r_sc) begin
          l_wins_n = l_wins + 4'd1; rnd_n = RND_WIN;
        end else if (l_sc < r_sc) begin
          r_wins_n = r_wins + 4'd1; rnd_n = RND_LOSE;
        end else begin
          rnd_n = RND_TIE;
        end
        rounds_n  = rounds + 4'd1;
        show_load = 1'b1;
        state_n   = S_SHOW;
      end
      S_SHOW: if (show_done) begin
        if (l_wins == WIN_TGT || r_wins == WIN_TGT || rounds == 4'(N_ROUNDS)) begin
          state_n    = S_DONE;
          blink_n    = 1'b1;
          blink_load = 1'b1;
          if (l_wins > r_wins)      res_n = RES_LOCAL;
          else if (l_wins < r_wins) res_n = RES_REMOTE;
          else                      res_n = RES_DRAW;
        end else begin
          state_n = S_COLLECT;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_n  = S_COLLECT;
          l_wins_n = '0; r_wins_n = '0; rounds_n = '0;
          l_got_n  = 1'b0; r_got_n = 1'b0;
          l_sc_n   = '0;   r_sc_n  = '0;
          res_n    = RES_NONE;
        end else if (blink_done) begin
          blink_n    = ~blink;
          blink_load = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    mo_n = (state_n == S_DONE);

    // LED image follows the next state so it switches together with it
    led_n = '0;
    unique case (state_n)
      S_COLLECT, S_COMPARE: begin
        led_n = LED_W'(therm(int'(l_wins_n), LED_W));
        rt    = LED_W'(therm(int'(r_wins_n), LED_W));
        for (int i = 0; i < LED_W; i++)
          led_n[LED_W-1-i] = led_n[LED_W-1-i] | rt[i];
      end
      S_SHOW: begin
        if (rnd_n == RND_WIN) led_n = '1;
        else if (rnd_n == RND_TIE)
          for (int i = 0; i < LED_W; i++) led_n[i] = i[0];
      end
      S_DONE: begin
        if (res_n == RES_LOCAL)     led_n = '1;
        else if (res_n == RES_DRAW) led_n = {LED_W{blink_n}};
      end
      default: led_n = '0;
    endcase
  end

  assign bus.led        = led_q;
  assign bus.l_wins     = l_wins;
  assign bus.r_wins     = r_wins;
  assign bus.match_over = mo_q;
  assign bus.result     = res_q;
endmodule

// File: doc/match_referee.md
# match_referee

Best-of-N match referee for two-board multiplayer. Captures the local and remote round scores through strobes and compares them once both are held. Keeps per-player round-win counters, declares a match winner, and drives the 16-LED bar with live progress, round result and final result. Sits between the local game core / inter-board link and the board LEDs.

## Interface
- SCORE_W, 4: width of both score inputs (unsigned)
- N_ROUNDS, 3: rounds per match, odd, 1..15
- LED_W, 16: LED bar width, even, >= 2*((N_ROUNDS+1)/2)
- SHOW_CYC, 50_000_000: cycles a round result is displayed
- BLINK_CYC, 12_500_000: half-period of the draw blink
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a new match from IDLE or DONE
- l_valid  in  1  pulse; local round finished, score valid
- score  in  SCORE_W  local round score
- r_valid  in  1  pulse; remote round score valid
- r_score  in  SCORE_W  remote round score
- led  out  LED_W  LED bar (registered)
- l_wins  out  4  local round wins
- r_wins  out  4  remote round wins
- match_over  out  1  high in DONE
- result  out  2  00 none, 01 local wins, 10 remote wins, 11 draw

## Operation
- States: IDLE, COLLECT, COMPARE, SHOW, DONE.
- IDLE: counters zero, led all 0. start -> COLLECT.
- COLLECT:
  - l_valid latches score and sets l_got; r_valid latches r_score and sets r_got.
  - A strobe for a side already held is ignored; the first value is kept.
  - Both strobes in the same cycle are both captured.
  - When l_got && r_got -> COMPARE.
- COMPARE (1 cycle), unsigned compare:
  - score > r_score: l_wins++, round result WIN.
  - score < r_score: r_wins++, round result LOSE.
  - Equal: round result TIE, no increment.
  - rounds_played++ in all three cases. Go to SHOW and clear l_got/r_got.
- SHOW: held for SHOW_CYC cycles, then test for end of match:
  - l_wins or r_wins == (N_ROUNDS+1)/2 -> DONE.
  - Otherwise rounds_played == N_ROUNDS -> DONE.
  - Otherwise -> COLLECT.
- Strobes arriving during COMPARE/SHOW are captured for the next round, with the same rules as COLLECT.
- DONE: result = 01 if l_wins > r_wins, 10 if less, 11 if equal. start -> clear counters and latches, go to COLLECT.
- LED patterns:
  - IDLE: all 0.
  - COLLECT: thermometer of l_wins from bit 0 upward, OR thermometer of r_wins from bit LED_W-1 downward.
  - SHOW: WIN all 1, LOSE all 0, TIE alternating 1010…(MSB=1).
  - DONE: local win all 1, remote win all 0, draw toggles all-1/all-0 every BLINK_CYC cycles, starting all-1.

## Timing
- Reset values: state IDLE, led 0, l_wins 0, r_wins 0, match_over 0, result 00, latches and flags cleared, timers 0.
- Reset mid-match aborts immediately. No score is retained.
- The second captured strobe is at edge T. Then state=COMPARE in T+1, and counters update and state=SHOW at T+2.
- led is registered from next-state/next-counter values, so it changes in the same cycle as the state.
- SHOW lasts exactly SHOW_CYC cycles.
- match_over and result go valid in the first DONE cycle and hold until start or reset.
- start is ignored outside IDLE/DONE.

## Structure
- Shared package match_pkg holds:
  - state enum
  - round-result enum (WIN, LOSE, TIE)
  - result encodings
  - thermometer function therm(n, width)
- One sub-module, match_timer: loadable down-counter with done pulse. It is instantiated twice, for the SHOW duration and the draw blink.
- Benches run with SHOW_CYC=4 and BLINK_CYC=2.

## Test plan
- Local win round: reset; start; l_valid score=9, then 3 cycles later r_valid r_score=5 -> COMPARE, l_wins=1, led=FFFF for 4 cycles, then led=0001.
- Simultaneous strobes: score=2, r_score=7 in the same cycle -> r_wins=1, SHOW led=0000, then led=8000.
- Duplicate strobe: l_valid 6, then l_valid 1, then r_valid 4 -> compare uses 6, local win.
- Early decision: local wins rounds 1 and 2 (N_ROUNDS=3) -> DONE after round 2, result=01, match_over=1, led=FFFF; round 3 never collected.
- Draw: three tied rounds (5 vs 5) -> each SHOW led=AAAA, DONE result=11, led alternates FFFF/0000 every 2 cycles; start returns to COLLECT with counters 0.
- Reset during SHOW -> next cycle led=0, l_wins=r_wins=0, state IDLE, strobes ignored until start.
